// File: rtl/player_motion_ctrl_pkg.sv
// player_motion_ctrl_pkg: motion FSM state encoding and screen bounds,
// shared with the overlay and draw controllers.
package player_motion_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RISE  = 3'd1,
        S_HOVER = 3'd2,
        S_FALL  = 3'd3,
        S_DEAD  = 3'd4
    } motion_state_t;

    localparam logic [7:0] SCREEN_WIDTH  = 8'd160;
    localparam logic [6:0] SCREEN_HEIGHT = 7'd120;

endpackage

// File: rtl/player_motion_ctrl_rise_edge_detect.sv
// rise_edge_detect: one-cycle pulse on a rising edge of a level input.
module rise_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic q;

    // Track the input through reset too, so a level held across reset is
    // already "seen" and does not produce a pulse once reset releases.
    always_ff @(posedge clock) begin
        q <= in;
    end

    assign pulse = in & ~q & ~reset;

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player sprite position, jump FSM
// (rise/hover/fall), sticky game-over latch and jump counter.
// Optional feature macro: DOUBLE_JUMP_EN (one extra airborne jump per landing).
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter logic [7:0] PLAYER_X     = 8'd20,
    parameter logic [6:0] GROUND_Y     = 7'd100,
    parameter logic [6:0] JUMP_HEIGHT  = 7'd30,
    parameter logic [6:0] RISE_STEP    = 7'd3,
    parameter logic [6:0] FALL_STEP    = 7'd2,
    parameter logic [3:0] HOVER_FRAMES = 4'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       jump_req,
    input  logic       sig_collision,
    output logic [7:0] player_x,
    output logic [6:0] player_y,
    output logic       airborne,
    output logic       game_over,
    output logic [7:0] jump_count
);

    localparam logic [6:0] APEX_FIXED = GROUND_Y - JUMP_HEIGHT;
    localparam logic [3:0] HOVER_LAST = HOVER_FRAMES - 4'd1;

    motion_state_t state, state_next;
    logic [6:0] y_next;
    logic [3:0] hover_cnt, hover_next;
    logic [7:0] count_next;
    logic       jump_pulse;
    logic       take_jump;
    logic [6:0] apex;
    logic [7:0] rise_floor;
    logic [6:0] rise_y;
    logic [7:0] fall_sum;
    logic [6:0] fall_y;

`ifdef DOUBLE_JUMP_EN
    logic [6:0] apex_q, apex_next;
    logic       credit_q, credit_next;
    logic [6:0] dj_apex;
    assign apex    = apex_q;
    assign dj_apex = ({1'b0, player_y} >= {1'b0, JUMP_HEIGHT}) ? player_y - JUMP_HEIGHT : '0;
`else
    assign apex = APEX_FIXED;
`endif

    assign player_x = PLAYER_X;

    rise_edge_detect u_jump_edge (
        .clock (clock),
        .reset (reset),
        .in    (jump_req),
        .pulse (jump_pulse)
    );

    // Next-state, position, hover and counter logic; priority collision > jump > tick.
    always_comb begin
        state_next = state;
        y_next     = player_y;
        hover_next = hover_cnt;
        count_next = jump_count;
        take_jump  = 1'b0;
`ifdef DOUBLE_JUMP_EN
        apex_next   = apex_q;
        credit_next = credit_q;
`endif
        // Clamped steps in 8 bits: never pass the apex going up or ground going down.
        rise_floor = {1'b0, apex} + {1'b0, RISE_STEP};
        rise_y     = ({1'b0, player_y} >= rise_floor) ? player_y - RISE_STEP : apex;
        fall_sum   = {1'b0, player_y} + {1'b0, FALL_STEP};
        fall_y     = (fall_sum >= {1'b0, GROUND_Y}) ? GROUND_Y : fall_sum[6:0];

        if (state != S_DEAD && sig_collision) begin
            state_next = S_DEAD;
        end else if (state == S_IDLE && jump_pulse) begin
            state_next = S_RISE;
            take_jump  = 1'b1;
`ifdef DOUBLE_JUMP_EN
            apex_next = dj_apex;
        end else if ((state == S_RISE || state == S_HOVER || state == S_FALL)
                     && jump_pulse && credit_q) begin
            state_next  = S_RISE;
            take_jump   = 1'b1;
            credit_next = 1'b0;
            apex_next   = dj_apex;
`endif
        end else if (frame_tick) begin
            case (state)
                S_RISE: begin
                    y_next = rise_y;
                    if (rise_y == apex) begin
                        state_next = S_HOVER;
                        hover_next = '0;
                    end
                end
                S_HOVER: begin
                    if (hover_cnt == HOVER_LAST) state_next = S_FALL;
                    else hover_next = hover_cnt + 4'd1;
                end
                S_FALL: begin
                    y_next = fall_y;
                    if (fall_y == GROUND_Y) begin
                        state_next = S_IDLE;
`ifdef DOUBLE_JUMP_EN
                        credit_next = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end

        if (take_jump && jump_count != 8'hFF) count_next = jump_count + 8'd1;
    end

    // Registered state and outputs; reset returns the sprite to the ground at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            player_y   <= GROUND_Y;
            hover_cnt  <= '0;
            jump_count <= '0;
            game_over  <= 1'b0;
            airborne   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            apex_q   <= APEX_FIXED;
            credit_q <= 1'b1;
`endif
        end else begin
            state      <= state_next;
            player_y   <= y_next;
            hover_cnt  <= hover_next;
            jump_count <= count_next;
            game_over  <= game_over | (state_next == S_DEAD);
            airborne   <= (state_next == S_RISE) || (state_next == S_HOVER) || (state_next == S_FALL);
`ifdef DOUBLE_JUMP_EN
            apex_q   <= apex_next;
            credit_q <= credit_next;
`endif
        end
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: scoreboard bench for player_motion_ctrl.
// Honours DOUBLE_JUMP_EN when the same define is given to the bench.
module tb_player_motion_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_req = 1'b0;
    logic       sig_collision = 1'b0;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic       airborne;
    logic       game_over;
    logic [7:0] jump_count;

    logic [16:0] observed;
    logic [16:0] exp_v;
    logic [16:0] sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase 0 idle, 1 rise, 2 hover, 3 fall, 4 dead.
    int m_phase = 0;
    int m_y     = 100;
    int m_cnt   = 0;
    int m_hov   = 0;
    int m_apex  = 70;
    bit m_go    = 0;
    bit m_prev  = 0;
    bit m_credit = 1;

    player_motion_ctrl u_dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .jump_req      (jump_req),
        .sig_collision (sig_collision),
        .player_x      (player_x),
        .player_y      (player_y),
        .airborne      (airborne),
        .game_over     (game_over),
        .jump_count    (jump_count)
    );

    always #5 clock = ~clock;

    assign observed = {player_y, airborne, game_over, jump_count};

    task automatic model(input bit rst, input bit jmp, input bit tick, input bit coll);
        bit e;
        bit air;
        e = jmp && !m_prev && !rst;
        m_prev = jmp;
        air = (m_phase >= 1 && m_phase <= 3);
        if (rst) begin
            m_phase = 0; m_y = 100; m_go = 0; m_cnt = 0; m_hov = 0; m_apex = 70; m_credit = 1;
        end else if (m_phase != 4 && coll) begin
            m_phase = 4; m_go = 1;
        end else if (m_phase == 0 && e) begin
            m_phase = 1; m_apex = 70;
            if (m_cnt < 255) m_cnt++;
`ifdef DOUBLE_JUMP_EN
        end else if (air && e && m_credit) begin
            m_phase = 1; m_credit = 0;
            m_apex = (m_y >= 30) ? m_y - 30 : 0;
            if (m_cnt < 255) m_cnt++;
`endif
        end else if (tick) begin
            if (m_phase == 1) begin
                m_y = m_y - 3;
                if (m_y <= m_apex) begin m_y = m_apex; m_phase = 2; m_hov = 0; end
            end else if (m_phase == 2) begin
                if (m_hov == 3) m_phase = 3; else m_hov++;
            end else if (m_phase == 3) begin
                m_y = m_y + 2;
                if (m_y >= 100) begin m_y = 100; m_phase = 0; m_credit = 1; end
            end
        end
        air = (m_phase >= 1 && m_phase <= 3);
        sb.push_back({7'(m_y), air, m_go, 8'(m_cnt)});
    endtask

    task automatic step(input bit rst, input bit jmp, input bit tick, input bit coll);
        reset = rst; jump_req = jmp; frame_tick = tick; sig_collision = coll;
        model(rst, jmp, tick, coll);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL reset_sb: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, (i % 2) == 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL idle_ticks: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if ({player_y, airborne, jump_count} !== {7'd100, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL idle_state: y=%0d air=%b cnt=%0d expected 100/0/0", player_y, airborne, jump_count);
        end
        n_checks++;
        if (player_x !== 8'd20) begin n_fail++; $display("FAIL player_x: got %0d expected 20", player_x); end
    endtask

    task automatic test_jump_arc();
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL jump_accept: got %h expected %h", observed, exp_v); end
        n_checks++;
        if (player_y !== 7'd100 || airborne !== 1'b1 || jump_count !== 8'd1) begin
            n_fail++; $display("FAIL jump_no_move: y=%0d air=%b cnt=%0d expected 100/1/1", player_y, airborne, jump_count);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL rise_sb: got %h expected %h", observed, exp_v); end
            n_checks++;
            if (player_y !== 7'(100 - 3 * (i + 1))) begin
                n_fail++; $display("FAIL rise_y: got %0d expected %0d", player_y, 100 - 3 * (i + 1));
            end
            step(0, 0, 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL rise_gap: got %h expected %h", observed, exp_v); end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL hover_sb: got %h expected %h", observed, exp_v); end
            n_checks++;
            if (player_y !== 7'd70) begin n_fail++; $display("FAIL hover_y: got %0d expected 70", player_y); end
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL fall_sb: got %h expected %h", observed, exp_v); end
            n_checks++;
            if (player_y !== 7'(70 + 2 * (i + 1))) begin
                n_fail++; $display("FAIL fall_y: got %0d expected %0d", player_y, 70 + 2 * (i + 1));
            end
        end
        n_checks++;
        if (airborne !== 1'b0 || jump_count !== 8'd1) begin
            n_fail++; $display("FAIL landed: air=%b cnt=%0d expected 0/1", airborne, jump_count);
        end
    endtask

    task automatic test_collision_on_jump();
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL coll_reset: got %h expected %h", observed, exp_v); end
        step(0, 1, 0, 1);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL coll_jump_sb: got %h expected %h", observed, exp_v); end
        n_checks++;
        if ({player_y, airborne, game_over, jump_count} !== {7'd100, 1'b0, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL coll_jump: y=%0d air=%b go=%b cnt=%0d expected 100/0/1/0",
                               player_y, airborne, game_over, jump_count);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, (i % 3) == 1, (i % 2) == 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL dead_hold: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if ({player_y, game_over, jump_count} !== {7'd100, 1'b1, 8'd0}) begin
            n_fail++; $display("FAIL dead_frozen: y=%0d go=%b cnt=%0d expected 100/1/0", player_y, game_over, jump_count);
        end
    endtask

    task automatic test_collision_midrise();
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL mid_reset: got %h expected %h", observed, exp_v); end
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL mid_jump: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL mid_rise: got %h expected %h", observed, exp_v); end
        end
        // collision and tick together: collision wins, no motion
        step(0, 0, 1, 1);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL mid_coll_sb: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 6; i++) begin
            step(0, (i % 2) == 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL mid_dead: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if (player_y !== 7'd82 || game_over !== 1'b1) begin
            n_fail++; $display("FAIL mid_frozen: y=%0d go=%b expected 82/1", player_y, game_over);
        end
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL mid_rst_sb: got %h expected %h", observed, exp_v); end
        n_checks++;
        if (player_y !== 7'd100 || game_over !== 1'b0 || airborne !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst: y=%0d go=%b air=%b expected 100/0/0", player_y, game_over, airborne);
        end
    endtask

    task automatic test_airborne_edge();
        bit landed;
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL air_reset: got %h expected %h", observed, exp_v); end
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL air_jump: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL air_rise: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if (player_y !== 7'd85) begin n_fail++; $display("FAIL air_y85: got %0d expected 85", player_y); end
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL air_edge: got %h expected %h", observed, exp_v); end
`ifdef DOUBLE_JUMP_EN
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL dj_rise: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if (player_y !== 7'd55) begin n_fail++; $display("FAIL dj_apex: got %0d expected 55", player_y); end
        step(0, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL dj_third: got %h expected %h", observed, exp_v); end
`endif
        landed = 0;
        for (int i = 0; i < 200 && !landed; i++) begin
            step(0, 0, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL air_land: got %h expected %h", observed, exp_v); end
            if (!airborne) landed = 1;
        end
        n_checks++;
        if (!landed) begin n_fail++; $display("FAIL air_timeout: airborne=%b expected 0 within 200 ticks", airborne); end
        n_checks++;
`ifdef DOUBLE_JUMP_EN
        if (jump_count !== 8'd2 || player_y !== 7'd100) begin
            n_fail++; $display("FAIL dj_count: cnt=%0d y=%0d expected 2/100", jump_count, player_y);
        end
`else
        if (jump_count !== 8'd1 || player_y !== 7'd100) begin
            n_fail++; $display("FAIL air_count: cnt=%0d y=%0d expected 1/100", jump_count, player_y);
        end
`endif
    endtask

    task automatic test_held_jump();
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL held_reset: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 200; i++) begin
            step(0, 1, (i % 2) == 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL held_sb: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if (jump_count !== 8'd1 || airborne !== 1'b0) begin
            n_fail++; $display("FAIL held_once: cnt=%0d air=%b expected 1/0", jump_count, airborne);
        end
        // key held through reset must not count as a new press
        step(1, 1, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL held_rst_sb: got %h expected %h", observed, exp_v); end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL held_rst_hold: got %h expected %h", observed, exp_v); end
        end
        n_checks++;
        if (jump_count !== 8'd0 || airborne !== 1'b0) begin
            n_fail++; $display("FAIL held_across_reset: cnt=%0d air=%b expected 0/0", jump_count, airborne);
        end
    endtask

    task automatic test_saturation();
        bit landed;
        step(1, 0, 0, 0);
        exp_v = sb.pop_front(); n_checks++;
        if (observed !== exp_v) begin n_fail++; $display("FAIL sat_reset: got %h expected %h", observed, exp_v); end
        for (int j = 0; j < 257; j++) begin
            step(0, 0, 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL sat_release: got %h expected %h", observed, exp_v); end
            step(0, 1, 0, 0);
            exp_v = sb.pop_front(); n_checks++;
            if (observed !== exp_v) begin n_fail++; $display("FAIL sat_press: got %h expected %h", observed, exp_v); end
            landed = 0;
            for (int i = 0; i < 100 && !landed; i++) begin
                step(0, 1, 1, 0);
                exp_v = sb.pop_front(); n_checks++;
                if (observed !== exp_v) begin n_fail++; $display("FAIL sat_flight: got %h expected %h", observed, exp_v); end
                if (!airborne) landed = 1;
            end
            n_checks++;
            if (!landed) begin n_fail++; $display("FAIL sat_timeout: jump %0d did not land in 100 ticks", j); end
            if (j == 254) begin
                n_checks++;
                if (jump_count !== 8'hFF) begin n_fail++; $display("FAIL sat_255: got %h expected ff", jump_count); end
            end
        end
        n_checks++;
        if (jump_count !== 8'hFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ff", jump_count); end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_jump_arc();
        test_collision_on_jump();
        test_collision_midrise();
        test_airborne_edge();
        test_held_jump();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
